uart_rx_operand_ctrl: RTL and testbench

UART_RX_OPERAND_CTRL -- requirements
Module: uart_rx_operand_ctrl

---
 rtl/uart_rx_operand_ctrl.sv | 192 +++++++++++++++++++
 tb/tb_uart_rx_operand_ctrl.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_operand_ctrl.sv
// -----------------------------------------------------------------------------
// uart_rx_operand_ctrl
//
// Collects bytes from a UART receiver into two little-endian operand words
// (A, then B) and presents them as a pair to a downstream consumer.
//
// Handshake: o_op_valid is high exactly while a complete pair is held; the
// pair is consumed on a clock edge where o_op_valid && i_op_ready, and the
// operands stay stable until that edge. Incoming bytes are one-cycle i_rx_done
// pulses with no ready of their own: a byte that arrives while a pair is held
// and not being consumed is dropped and reported on o_overrun.
//
// Optional feature (macro UART_RX_TIMEOUT_EN): an inter-byte timeout counted
// in i_stick ticks. Once a frame is under way, TIMEOUT_TICKS ticks without a
// new byte discard the partial frame and pulse o_timeout. Without the macro
// there is no counter, o_timeout is tied low and a partial frame waits forever.
//
// Parameters
//   SIZE_DATA       UART byte width
//   BYTES_PER_WORD  bytes per operand word (>= 1)
//   TIMEOUT_TICKS   i_stick ticks allowed between bytes of one frame (>= 1)
//
// Ports
//   i_clk        clock
//   i_rst_n      asynchronous active-low reset
//   i_stick      baud-rate tick (one-cycle pulse), used only by the timeout
//   i_clear      synchronous abort, discards the partial frame / held pair
//   i_rx_data    received byte
//   i_rx_done    one-cycle pulse, i_rx_data valid
//   o_rx_en      receiver enable (high from the first edge after reset)
//   o_fifo_full  backpressure to the receiver while a pair is held
//   o_op_a       operand A
//   o_op_b       operand B
//   o_op_valid   operand pair valid
//   i_op_ready   consumer accepts the operand pair
//   o_overrun    one-cycle pulse, a byte was dropped
//   o_timeout    one-cycle pulse, a partial frame was discarded
//   o_dbg_state  FSM state (0 COLLECT_A, 1 COLLECT_B, 2 VALID)
//   o_dbg_cnt    byte counter within the active operand
// -----------------------------------------------------------------------------
module uart_rx_operand_ctrl #(
  parameter int SIZE_DATA      = 8,
  parameter int BYTES_PER_WORD = 4,
  parameter int TIMEOUT_TICKS  = 2048
) (
  input  logic                                i_clk,
  input  logic                                i_rst_n,
  input  logic                                i_stick,
  input  logic                                i_clear,
  input  logic [SIZE_DATA-1:0]                i_rx_data,
  input  logic                                i_rx_done,
  output logic                                o_rx_en,
  output logic                                o_fifo_full,
  output logic [SIZE_DATA*BYTES_PER_WORD-1:0] o_op_a,
  output logic [SIZE_DATA*BYTES_PER_WORD-1:0] o_op_b,
  output logic                                o_op_valid,
  input  logic                                i_op_ready,
  output logic                                o_overrun,
  output logic                                o_timeout,
  output logic [1:0]                          o_dbg_state,
  output logic [7:0]                          o_dbg_cnt
);

  localparam int WORD_W = SIZE_DATA * BYTES_PER_WORD;
  localparam int CNT_W  = (BYTES_PER_WORD > 1) ? $clog2(BYTES_PER_WORD) : 1;
  localparam logic [CNT_W-1:0] LAST_LANE = CNT_W'(BYTES_PER_WORD - 1);

  typedef enum logic [1:0] {
    COLLECT_A = 2'd0,
    COLLECT_B = 2'd1,
    VALID     = 2'd2
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;

  // State/lane an incoming byte is applied to this cycle. A handshake or a
  // timeout restarts the frame first, so a byte in the same cycle becomes
  // byte 0 of the new operand A.
  state_t           eff_state;
  logic [CNT_W-1:0] eff_cnt;
  logic             take_byte;
  logic [WORD_W-1:0] merged;
  logic             to_hit;

`ifdef UART_RX_TIMEOUT_EN
  localparam int TO_W = (TIMEOUT_TICKS > 1) ? $clog2(TIMEOUT_TICKS + 1) : 1;
  logic [TO_W-1:0] to_cnt;
  logic            to_armed;

  // Armed only once a frame has started (at least one byte received).
  assign to_armed = (state == COLLECT_B) ||
                    ((state == COLLECT_A) && (cnt != '0));
  assign to_hit   = to_armed && i_stick && (to_cnt == TO_W'(TIMEOUT_TICKS - 1));

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      to_cnt <= '0;
    end else if (i_clear || to_hit || take_byte || !to_armed) begin
      to_cnt <= '0;
    end else if (i_stick) begin
      to_cnt <= to_cnt + 1'b1;
    end
  end
`else
  logic unused_stick;
  assign unused_stick = i_stick;
  assign to_hit       = 1'b0;
`endif

  always_comb begin
    eff_state = state;
    eff_cnt   = cnt;
    if (to_hit || ((state == VALID) && i_op_ready)) begin
      eff_state = COLLECT_A;
      eff_cnt   = '0;
    end
  end

  assign take_byte = i_rx_done && (eff_state != VALID);

  // Active operand with the incoming byte dropped into lane eff_cnt.
  always_comb begin
    merged = (eff_state == COLLECT_B) ? o_op_b : o_op_a;
    for (int l = 0; l < BYTES_PER_WORD; l++) begin
      if (eff_cnt == CNT_W'(l)) begin
        merged[l*SIZE_DATA +: SIZE_DATA] = i_rx_data;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state       <= COLLECT_A;
      cnt         <= '0;
      o_op_a      <= '0;
      o_op_b      <= '0;
      o_op_valid  <= 1'b0;
      o_fifo_full <= 1'b0;
      o_rx_en     <= 1'b0;
      o_overrun   <= 1'b0;
      o_timeout   <= 1'b0;
    end else begin
      o_rx_en <= 1'b1;
      if (i_clear) begin
        // Abort wins over bytes, handshakes and timeouts; operands are kept.
        state       <= COLLECT_A;
        cnt         <= '0;
        o_op_valid  <= 1'b0;
        o_fifo_full <= 1'b0;
        o_overrun   <= 1'b0;
        o_timeout   <= 1'b0;
      end else begin
        o_overrun <= i_rx_done && (eff_state == VALID);
        o_timeout <= to_hit;
        if (take_byte) begin
          if (eff_state == COLLECT_A) begin
            o_op_a <= merged;
          end else begin
            o_op_b <= merged;
          end
          if (eff_cnt == LAST_LANE) begin
            cnt <= '0;
            if (eff_state == COLLECT_A) begin
              state       <= COLLECT_B;
              o_op_valid  <= 1'b0;
              o_fifo_full <= 1'b0;
            end else begin
              state       <= VALID;
              o_op_valid  <= 1'b1;
              o_fifo_full <= 1'b1;
            end
          end else begin
            state       <= eff_state;
            cnt         <= eff_cnt + 1'b1;
            o_op_valid  <= 1'b0;
            o_fifo_full <= 1'b0;
          end
        end else begin
          state       <= eff_state;
          cnt         <= eff_cnt;
          o_op_valid  <= (eff_state == VALID);
          o_fifo_full <= (eff_state == VALID);
        end
      end
    end
  end

  assign o_dbg_state = state;
  assign o_dbg_cnt   = 8'(cnt);

endmodule

// File: tb/tb_uart_rx_operand_ctrl.sv
module tb_uart_rx_operand_ctrl;

  logic        clk;
  logic        rst_n;
  logic        stick;
  logic        clear;
  logic [7:0]  rx_data;
  logic        rx_done;
  logic        rx_en;
  logic        fifo_full;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic        op_valid;
  logic        op_ready;
  logic        overrun;
  logic        timeout;
  logic [1:0]  dbg_state;
  logic [7:0]  dbg_cnt;

  int total = 0;
  int bad   = 0;
  int n_overrun = 0;
  int n_timeout = 0;

  logic [63:0] exp_q[$];
  logic [63:0] exp_w;

  uart_rx_operand_ctrl #(
    .SIZE_DATA(8), .BYTES_PER_WORD(4), .TIMEOUT_TICKS(4)
  ) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_stick(stick), .i_clear(clear),
    .i_rx_data(rx_data), .i_rx_done(rx_done), .o_rx_en(rx_en),
    .o_fifo_full(fifo_full), .o_op_a(op_a), .o_op_b(op_b),
    .o_op_valid(op_valid), .i_op_ready(op_ready), .o_overrun(overrun),
    .o_timeout(timeout), .o_dbg_state(dbg_state), .o_dbg_cnt(dbg_cnt)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: sim time exceeded, got no finish, want finish");
    $fatal(1);
  end

  // Pulse counters, sampled shortly after each rising edge.
  always @(posedge clk) begin
    #2;
    if (overrun) n_overrun++;
    if (timeout) n_timeout++;
  end

  // ---------------- driver tasks ----------------
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    rx_data = b;
    rx_done = 1'b1;
    @(negedge clk);
    rx_done = 1'b0;
  endtask

  task automatic tick();
    @(negedge clk);
    stick = 1'b1;
    @(negedge clk);
    stick = 1'b0;
  endtask

  task automatic handshake();
    @(negedge clk);
    op_ready = 1'b1;
    @(negedge clk);
    op_ready = 1'b0;
  endtask

  task automatic send_pair(input logic [31:0] a, input logic [31:0] b);
    logic [63:0] w;
    w = {b, a};
    exp_q.push_back(w);
    for (int i = 0; i < 8; i++) begin
      idle($urandom_range(0, 2));
      send_byte(w[8*i +: 8]);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0; stick = 1'b0; clear = 1'b0; rx_data = '0; rx_done = 1'b0; op_ready = 1'b0;
    idle(3);
    total++; if (rx_en !== 1'b0) begin bad++; $display("FAIL reset_rx_en: got %b want 0", rx_en); end
    total++; if ({op_valid, fifo_full, overrun, timeout} !== 4'b0) begin bad++; $display("FAIL reset_flags: got %b want 0000", {op_valid, fifo_full, overrun, timeout}); end
    total++; if ({op_b, op_a} !== 64'h0) begin bad++; $display("FAIL reset_ops: got %h want 0", {op_b, op_a}); end
    total++; if ({dbg_state, dbg_cnt} !== 10'h0) begin bad++; $display("FAIL reset_state: got %h want 0", {dbg_state, dbg_cnt}); end
    rst_n = 1'b1;
    @(negedge clk);
    total++; if (rx_en !== 1'b1) begin bad++; $display("FAIL rx_en_after_reset: got %b want 1", rx_en); end
  endtask

  task automatic test_basic_pair();
    logic [63:0] w;
    w = {32'h40000000, 32'h3F800000};
    exp_q.push_back(w);
    for (int i = 0; i < 7; i++) send_byte(w[8*i +: 8]);
    total++; if (op_valid !== 1'b0 || dbg_state !== 2'd1 || dbg_cnt !== 8'd3) begin bad++; $display("FAIL basic_before_last: got valid=%b state=%0d cnt=%0d want 0/1/3", op_valid, dbg_state, dbg_cnt); end
    total++; if (fifo_full !== 1'b0 || rx_en !== 1'b1) begin bad++; $display("FAIL basic_collect_flags: got full=%b en=%b want 0/1", fifo_full, rx_en); end
    send_byte(w[63:56]);
    total++; if (op_valid !== 1'b1 || fifo_full !== 1'b1 || rx_en !== 1'b1) begin bad++; $display("FAIL basic_valid: got valid=%b full=%b en=%b want 1/1/1", op_valid, fifo_full, rx_en); end
    total++; if (op_a !== 32'h3F800000 || op_b !== 32'h40000000) begin bad++; $display("FAIL basic_ops: got a=%h b=%h want 3f800000/40000000", op_a, op_b); end
  endtask

  task automatic test_overrun();
    int ov0;
    ov0 = n_overrun;
    op_ready = 1'b0;
    send_byte(8'h55);
    total++; if (overrun !== 1'b1) begin bad++; $display("FAIL overrun_pulse: got %b want 1", overrun); end
    @(negedge clk);
    total++; if (overrun !== 1'b0) begin bad++; $display("FAIL overrun_one_cycle: got %b want 0", overrun); end
    idle(2);
    total++; if (n_overrun - ov0 !== 1) begin bad++; $display("FAIL overrun_count: got %0d want 1", n_overrun - ov0); end
    total++; if (op_a !== 32'h3F800000 || op_b !== 32'h40000000) begin bad++; $display("FAIL overrun_ops_held: got a=%h b=%h want 3f800000/40000000", op_a, op_b); end
    total++; if (op_valid !== 1'b1 || fifo_full !== 1'b1) begin bad++; $display("FAIL overrun_still_valid: got valid=%b full=%b want 1/1", op_valid, fifo_full); end
  endtask

  task automatic test_back_to_back();
    logic [7:0]  r [3];
    logic [31:0] nb;
    int ov0;
    // consume the held pair through the scoreboard
    if (exp_q.size() == 0) begin total++; bad++; $display("FAIL b2b_queue: got empty want entry"); end
    else begin
      exp_w = exp_q.pop_front();
      total++; if ({op_b, op_a} !== exp_w) begin bad++; $display("FAIL b2b_held_pair: got %h want %h", {op_b, op_a}, exp_w); end
    end
    ov0 = n_overrun;
    @(negedge clk);
    op_ready = 1'b1; rx_data = 8'hAA; rx_done = 1'b1;
    @(negedge clk);
    op_ready = 1'b0; rx_done = 1'b0;
    total++; if (op_valid !== 1'b0 || dbg_state !== 2'd0 || dbg_cnt !== 8'd1) begin bad++; $display("FAIL b2b_state: got valid=%b state=%0d cnt=%0d want 0/0/1", op_valid, dbg_state, dbg_cnt); end
    idle(1);
    total++; if (n_overrun != ov0) begin bad++; $display("FAIL b2b_no_overrun: got %0d pulses want 0", n_overrun - ov0); end
    for (int i = 0; i < 3; i++) r[i] = 8'($urandom_range(0, 255));
    nb = $urandom;
    exp_q.push_back({nb, r[2], r[1], r[0], 8'hAA});
    for (int i = 0; i < 3; i++) send_byte(r[i]);
    for (int i = 0; i < 4; i++) send_byte(nb[8*i +: 8]);
    total++; if (op_a[7:0] !== 8'hAA) begin bad++; $display("FAIL b2b_lane0: got %h want aa", op_a[7:0]); end
    exp_w = exp_q.pop_front();
    total++; if (op_valid !== 1'b1 || {op_b, op_a} !== exp_w) begin bad++; $display("FAIL b2b_pair: got v=%b %h want v=1 %h", op_valid, {op_b, op_a}, exp_w); end
    handshake();
  endtask

  task automatic test_random_pairs();
    for (int k = 0; k < 4; k++) begin
      send_pair($urandom, $urandom);
      exp_w = exp_q.pop_front();
      total++; if (op_valid !== 1'b1 || {op_b, op_a} !== exp_w) begin bad++; $display("FAIL rand_pair%0d: got v=%b %h want v=1 %h", k, op_valid, {op_b, op_a}, exp_w); end
      idle($urandom_range(0, 3));
      total++; if ({op_b, op_a} !== exp_w) begin bad++; $display("FAIL rand_hold%0d: got %h want %h", k, {op_b, op_a}, exp_w); end
      handshake();
      total++; if (op_valid !== 1'b0 || fifo_full !== 1'b0) begin bad++; $display("FAIL rand_release%0d: got valid=%b full=%b want 0/0", k, op_valid, fifo_full); end
    end
  endtask

  task automatic test_clear();
    logic [7:0] b [5];
    for (int i = 0; i < 5; i++) b[i] = 8'($urandom_range(0, 255));
    for (int i = 0; i < 5; i++) send_byte(b[i]);
    // clear together with a byte: the byte must be ignored
    @(negedge clk);
    clear = 1'b1; rx_data = 8'h99; rx_done = 1'b1;
    @(negedge clk);
    clear = 1'b0; rx_done = 1'b0;
    total++; if (dbg_state !== 2'd0 || dbg_cnt !== 8'd0 || op_valid !== 1'b0) begin bad++; $display("FAIL clear_state: got state=%0d cnt=%0d valid=%b want 0/0/0", dbg_state, dbg_cnt, op_valid); end
    total++; if (op_a !== {b[3], b[2], b[1], b[0]} || op_b[7:0] !== b[4]) begin bad++; $display("FAIL clear_ops_kept: got a=%h b0=%h want %h/%h", op_a, op_b[7:0], {b[3], b[2], b[1], b[0]}, b[4]); end
    // clear while a pair is held
    send_pair($urandom, $urandom);
    exp_w = exp_q.pop_front();
    @(negedge clk);
    clear = 1'b1; op_ready = 1'b1;
    @(negedge clk);
    clear = 1'b0; op_ready = 1'b0;
    total++; if (op_valid !== 1'b0 || fifo_full !== 1'b0 || {op_b, op_a} !== exp_w) begin bad++; $display("FAIL clear_valid: got v=%b f=%b %h want 0/0 %h", op_valid, fifo_full, {op_b, op_a}, exp_w); end
  endtask

  task automatic test_timeout();
    logic [63:0] w;
    int to0;
    to0 = n_timeout;
    w = {$urandom, $urandom};
`ifdef UART_RX_TIMEOUT_EN
    for (int i = 0; i < 3; i++) send_byte(w[8*i +: 8]);
    for (int i = 0; i < 3; i++) tick();
    total++; if (n_timeout != to0 || dbg_cnt !== 8'd3) begin bad++; $display("FAIL timeout_early: got pulses=%0d cnt=%0d want 0/3", n_timeout - to0, dbg_cnt); end
    tick();
    total++; if (timeout !== 1'b1 || dbg_cnt !== 8'd0 || dbg_state !== 2'd0) begin bad++; $display("FAIL timeout_hit: got to=%b cnt=%0d state=%0d want 1/0/0", timeout, dbg_cnt, dbg_state); end
    idle(2);
    total++; if (n_timeout - to0 != 1) begin bad++; $display("FAIL timeout_count: got %0d want 1", n_timeout - to0); end
    send_pair(w[31:0], w[63:32]);
`else
    exp_q.push_back(w);
    for (int i = 0; i < 3; i++) send_byte(w[8*i +: 8]);
    for (int i = 0; i < 12; i++) tick();
    total++; if (n_timeout != to0 || timeout !== 1'b0 || dbg_cnt !== 8'd3) begin bad++; $display("FAIL no_timeout_hold: got pulses=%0d cnt=%0d want 0/3", n_timeout - to0, dbg_cnt); end
    for (int i = 3; i < 8; i++) send_byte(w[8*i +: 8]);
`endif
    exp_w = exp_q.pop_front();
    total++; if (op_valid !== 1'b1 || {op_b, op_a} !== exp_w) begin bad++; $display("FAIL timeout_pair: got v=%b %h want v=1 %h", op_valid, {op_b, op_a}, exp_w); end
    handshake();
  endtask

  task automatic test_reset_midframe();
    int ov0, to0;
    ov0 = n_overrun; to0 = n_timeout;
    for (int i = 0; i < 3; i++) send_byte(8'($urandom_range(1, 255)));
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    total++; if ({rx_en, op_valid, fifo_full, overrun, timeout} !== 5'b0) begin bad++; $display("FAIL midreset_flags: got %b want 00000", {rx_en, op_valid, fifo_full, overrun, timeout}); end
    total++; if ({op_b, op_a} !== 64'h0 || dbg_state !== 2'd0 || dbg_cnt !== 8'd0) begin bad++; $display("FAIL midreset_regs: got %h st=%0d cnt=%0d want 0", {op_b, op_a}, dbg_state, dbg_cnt); end
    idle(3);
    rst_n = 1'b1;
    idle(4);
    total++; if (n_overrun != ov0 || n_timeout != to0) begin bad++; $display("FAIL midreset_pulses: got ov=%0d to=%0d want 0/0", n_overrun - ov0, n_timeout - to0); end
    send_pair($urandom, $urandom);
    exp_w = exp_q.pop_front();
    total++; if (op_valid !== 1'b1 || {op_b, op_a} !== exp_w) begin bad++; $display("FAIL midreset_pair: got v=%b %h want v=1 %h", op_valid, {op_b, op_a}, exp_w); end
    handshake();
  endtask

  // ---------------- sequence / report ----------------
  initial begin
    test_reset();
    test_basic_pair();
    test_overrun();
    test_back_to_back();
    test_random_pairs();
    test_clear();
    test_timeout();
    test_reset_midframe();
    total++; if (exp_q.size() != 0) begin bad++; $display("FAIL scoreboard_leftover: got %0d want 0", exp_q.size()); end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
